// File: rtl/rtype_seq_pkg.sv
// Shared types and constants for the R-type instruction sequencer.
package rtype_seq_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StWb     = 2'd3
    } state_e;

    // R-type opcode field value.
    localparam logic [5:0] OpRtype  = 6'h00;

    // Func field codes.
    localparam logic [5:0] FuncAdd  = 6'h20;
    localparam logic [5:0] FuncAddu = 6'h21;
    localparam logic [5:0] FuncSub  = 6'h22;
    localparam logic [5:0] FuncSubu = 6'h23;
    localparam logic [5:0] FuncAnd  = 6'h24;
    localparam logic [5:0] FuncOr   = 6'h25;
    localparam logic [5:0] FuncXor  = 6'h26;
    localparam logic [5:0] FuncNor  = 6'h27;
    localparam logic [5:0] FuncSlt  = 6'h2A;
    localparam logic [5:0] FuncSltu = 6'h2B;

    // ALU control codes.
    localparam logic [3:0] AluAdd  = 4'b1010;
    localparam logic [3:0] AluAddu = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b1110;
    localparam logic [3:0] AluSubu = 4'b0110;
    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluXor  = 4'b0011;
    localparam logic [3:0] AluNor  = 4'b1100;
    localparam logic [3:0] AluSlt  = 4'b1101;
    localparam logic [3:0] AluSltu = 4'b1111;

endpackage

// File: rtl/rtype_decode.sv
// Combinational Op/Func to ALU control decoder for supported R-type instructions.
module rtype_decode
    import rtype_seq_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] alu_cntl,
    output logic       legal
);

    // Map Func to ALU code; anything outside the table or non-zero Op is illegal.
    always_comb begin
        alu_cntl = AluAnd;
        legal    = 1'b1;
        case (func)
            FuncAdd:  alu_cntl = AluAdd;
            FuncAddu: alu_cntl = AluAddu;
            FuncSub:  alu_cntl = AluSub;
            FuncSubu: alu_cntl = AluSubu;
            FuncAnd:  alu_cntl = AluAnd;
            FuncOr:   alu_cntl = AluOr;
            FuncXor:  alu_cntl = AluXor;
            FuncNor:  alu_cntl = AluNor;
            FuncSlt:  alu_cntl = AluSlt;
            FuncSltu: alu_cntl = AluSltu;
            default:  legal    = 1'b0;
        endcase
        if (op != OpRtype) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type instruction sequencer: IDLE -> DECODE -> EXEC -> WB.
// Optional feature macro: RTYPE_SEQ_OVF_TRAP_EN (suppress overflowing add/sub writes).
module rtype_sequencer
    import rtype_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [3:0]  alu_cntl,
    input  logic        alu_ovf,
    output logic        reg_write,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        ovf_trap
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic [3:0]  alu_cntl_q;
    // Low throughout reset, high from the first edge after release; gates instr_ready.
    logic        started_q;
    logic [3:0]  dec_alu_cntl;
    logic        dec_legal;
    logic        accept;
    logic        ovf_hit;

    rtype_decode u_decode (
        .op       (instr_q[31:26]),
        .func     (instr_q[5:0]),
        .alu_cntl (dec_alu_cntl),
        .legal    (dec_legal)
    );

    assign accept   = instr_valid && instr_ready;
    assign rs_addr  = instr_q[25:21];
    assign rt_addr  = instr_q[20:16];
    assign rd_addr  = instr_q[15:11];
    assign alu_cntl = alu_cntl_q;

`ifdef RTYPE_SEQ_OVF_TRAP_EN
    // Signed overflow only matters for add and sub; the unsigned forms never trap.
    assign ovf_hit = alu_ovf && ((instr_q[5:0] == FuncAdd) || (instr_q[5:0] == FuncSub));
    logic unused_shamt;
    assign unused_shamt = ^instr_q[10:6];
`else
    assign ovf_hit = 1'b0;
    logic unused_sig;
    assign unused_sig = alu_ovf ^ (^instr_q[10:6]);
`endif

    // State, instruction latch, ALU control register and ready-enable flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            instr_q    <= 32'd0;
            alu_cntl_q <= 4'b0000;
            started_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (accept) begin
                instr_q <= instr;
            end
            if ((state_q == StDecode) && dec_legal) begin
                alu_cntl_q <= dec_alu_cntl;
            end
        end
    end

    // Next state and per-state output pulses.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        reg_write   = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        ovf_trap    = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy        = 1'b0;
                instr_ready = started_q;
                if (accept) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    state_d = StExec;
                end else begin
                    illegal = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                state_d = StWb;
            end
            StWb: begin
                done      = 1'b1;
                ovf_trap  = ovf_hit;
                reg_write = (instr_q[15:11] != 5'd0) && !ovf_hit;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/rtype_sequencer.md
RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

Interface
REQ-001 The port list SHALL be exactly as below; there is one clock, and reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous active-low reset; low forces reset state immediately.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  32  MIPS instruction word.
- rs_addr  output  5  register-file read port A address, instr[25:21].
- rt_addr  output  5  register-file read port B address, instr[20:16].
- rd_addr  output  5  register-file write address, instr[15:11].
- alu_cntl  output  4  ALU control code.
- alu_ovf  input  1  ALU signed-overflow flag for the current operands.
- reg_write  output  1  register-file write enable, one-cycle pulse.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on instruction retirement, including retirement as illegal.
- illegal  output  1  one-cycle pulse with done for an unsupported instruction.
- ovf_trap  output  1  one-cycle pulse with done for a suppressed overflowing write.

Function
REQ-002 FSM states SHALL be IDLE, DECODE, EXEC, WB, encoded in 2 bits.
REQ-003 IDLE: instr_ready=1. When instr_valid&&instr_ready, instr SHALL be latched into an internal register and the FSM SHALL go to DECODE; instr_ready=0 in all other states.
REQ-004 rs_addr, rt_addr and rd_addr SHALL be driven from the latched instruction and held stable from DECODE through WB.
REQ-005 DECODE: Op=instr[31:26] and Func=instr[5:0] SHALL be mapped to a registered alu_cntl as follows:
- 0x20 → 1010 (add)
- 0x21 → 0010 (addu)
- 0x22 → 1110 (sub)
- 0x23 → 0110 (subu)
- 0x24 → 0000 (and)
- 0x25 → 0001 (or)
- 0x26 → 0011 (xor)
- 0x27 → 1100 (nor)
- 0x2A → 1101 (slt)
- 0x2B → 1111 (sltu)
REQ-006 If Op≠0 or Func is not in the table, DECODE SHALL assert illegal=1 and done=1 for one cycle, SHALL NOT assert reg_write, and SHALL return to IDLE.
REQ-007 A legal instruction SHALL go DECODE→EXEC→WB; alu_cntl SHALL be held constant from EXEC through WB.
REQ-008 WB: reg_write=1 and done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-009 If rd_addr=0, reg_write SHALL stay 0 in WB; done still pulses.
REQ-010 Latency: handshake at edge N gives done at cycle N+3 for a legal instruction and N+1 for an illegal one. Peak throughput SHALL be one instruction per 4 cycles.
REQ-011 instr_valid while busy SHALL be ignored; the upstream holds it until instr_ready.
REQ-012 In IDLE, alu_cntl SHALL hold its last value, and reg_write, done, illegal and ovf_trap SHALL be 0.

Reset
REQ-013 While reset is low: state=IDLE, latched instruction=0, alu_cntl=0000, reg_write=0, done=0, illegal=0, ovf_trap=0, busy=0, instr_ready=0.
REQ-014 instr_ready SHALL rise on the first clock edge after reset deasserts.
REQ-015 Reset asserted in any state SHALL abort the instruction with no reg_write and no done.

Configuration
REQ-016 With RTYPE_SEQ_OVF_TRAP_EN defined, a WB of add (0x20) or sub (0x22) with alu_ovf=1 SHALL suppress reg_write and pulse ovf_trap with done.
REQ-017 Without RTYPE_SEQ_OVF_TRAP_EN, alu_ovf SHALL be ignored and ovf_trap SHALL be tied to 0.

Structure
REQ-018 A shared package rtype_seq_pkg SHALL hold the state enum, the Func code constants and the ALU control code constants.
REQ-019 The Func→alu_cntl mapping SHALL be a combinational sub-module rtype_decode with outputs alu_cntl and legal, instantiated once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- instr=0x00221820 (add $3,$1,$2) → rs_addr=1, rt_addr=2, rd_addr=3, alu_cntl=1010, reg_write and done at cycle N+3.
- instr=0x8C220004 (lw) → illegal=1 and done=1 at cycle N+1, reg_write never asserted, instr_ready=1 at N+2.
- instr=0x00220025 (or $0,$1,$2) → alu_cntl=0001, done at N+3, reg_write stays 0.
- instr=0x00221822 (sub) with alu_ovf=1 → with macro: ovf_trap=1, reg_write=0; without macro: reg_write=1, ovf_trap=0.
- Back-to-back valid instructions 0x0022182A then 0x0022182B → second accepted at N+4, alu_cntl 1101 then 1111; instr_valid during busy ignored.
- reset low during EXEC → outputs reach reset values immediately, no done; after release instr_ready=1 on the next edge.
